// File: rtl/knight_anim_pkg.sv
// knight_anim_pkg: shared types and helpers for the knight sprite controllers.
//   anim_state_t : animation FSM states (IDLE, PLAY, DONE)
//   SPR_ADDR_W   : sprite ROM address width
//   PAL_IDX_W    : palette index width
//   sprite_addr  : row-major sprite ROM address (dy*w + dx)
package knight_anim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } anim_state_t;

  localparam int unsigned SPR_ADDR_W = 12;
  localparam int unsigned PAL_IDX_W  = 3;

  function automatic logic [SPR_ADDR_W-1:0] sprite_addr(
    input logic [9:0] dx,
    input logic [9:0] dy,
    input logic [9:0] w
  );
    logic [19:0] p;
    p = 20'(dy) * 20'(w) + 20'(dx);
    return p[SPR_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sprite_box_addr.sv
// sprite_box_addr: sprite bounding-box test and registered ROM address.
//   clk, reset    : clock, synchronous active-high reset
//   frame_tick    : (KNIGHT_DEATH_MIRROR_EN only) frame strobe for mirror latch
//   facing_left   : (KNIGHT_DEATH_MIRROR_EN only) mirror request
//   pos_x, pos_y  : sprite box top-left corner
//   draw_x, draw_y: current pixel
//   in_box        : combinational, pixel inside the box
//   address       : registered row-major ROM address, 0 outside the box
// Optional macro: KNIGHT_DEATH_MIRROR_EN adds horizontal mirroring.
import knight_anim_pkg::*;

module sprite_box_addr #(
  parameter int unsigned SPR_W = 50,
  parameter int unsigned SPR_H = 64
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef KNIGHT_DEATH_MIRROR_EN
  input  logic                  frame_tick,
  input  logic                  facing_left,
`endif
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic [9:0]            draw_x,
  input  logic [9:0]            draw_y,
  output logic                  in_box,
  output logic [SPR_ADDR_W-1:0] address
);

  logic [10:0] x_end, y_end;
  logic [9:0]  dx, dy, dx_eff;

  // Box end computed in 11 bits so a box hanging off the right/bottom edge
  // does not wrap around to a small value.
  always_comb begin
    x_end  = {1'b0, pos_x} + 11'(SPR_W);
    y_end  = {1'b0, pos_y} + 11'(SPR_H);
    in_box = (draw_x >= pos_x) && ({1'b0, draw_x} < x_end) &&
             (draw_y >= pos_y) && ({1'b0, draw_y} < y_end);
    dx     = draw_x - pos_x;
    dy     = draw_y - pos_y;
  end

`ifdef KNIGHT_DEATH_MIRROR_EN
  logic mirror;

  // Latched only on the frame strobe so one video frame is never torn.
  always_ff @(posedge clk) begin
    if (reset)           mirror <= 1'b0;
    else if (frame_tick) mirror <= facing_left;
  end

  always_comb dx_eff = mirror ? (10'(SPR_W - 1) - dx) : dx;
`else
  always_comb dx_eff = dx;
`endif

  always_ff @(posedge clk) begin
    if (reset)       address <= '0;
    else if (in_box) address <= sprite_addr(dx_eff, dy, 10'(SPR_W));
    else             address <= '0;
  end

endmodule

// File: rtl/knight_death_anim_ctrl.sv
// knight_death_anim_ctrl: knight death animation sequencer.
//   vga_clk     : pixel clock
//   Reset       : synchronous active-high reset
//   frame_tick  : one-cycle pulse per video frame
//   die         : starts the animation from IDLE
//   pos_x/pos_y : sprite box top-left corner
//   DrawX/DrawY : current pixel
//   rom_q       : palette index from the selected frame ROM
//   rom_address : registered sprite ROM address
//   frame_sel   : current animation frame
//   sprite_on   : pixel in box and non-transparent, aligned with index_out
//   index_out   : registered palette index
//   busy / done : animation playing / finished
// Optional macro: KNIGHT_DEATH_MIRROR_EN adds input facing_left.
import knight_anim_pkg::*;

module knight_death_anim_ctrl #(
  parameter int unsigned SPR_W       = 50,
  parameter int unsigned SPR_H       = 64,
  parameter int unsigned NUM_FRAMES  = 4,
  parameter int unsigned HOLD_FRAMES = 8,
  parameter int unsigned ROM_LAT     = 1,
  parameter int unsigned TRANSP_IDX  = 0
) (
  input  logic                  vga_clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic                  die,
`ifdef KNIGHT_DEATH_MIRROR_EN
  input  logic                  facing_left,
`endif
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic [PAL_IDX_W-1:0]  rom_q,
  output logic [SPR_ADDR_W-1:0] rom_address,
  output logic [1:0]            frame_sel,
  output logic                  sprite_on,
  output logic [PAL_IDX_W-1:0]  index_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  anim_state_t       state, state_n;
  logic [1:0]        frame_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic              in_box;
  logic [ROM_LAT:0]  valid_sr;

  sprite_box_addr #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_box (
    .clk         (vga_clk),
    .reset       (Reset),
`ifdef KNIGHT_DEATH_MIRROR_EN
    .frame_tick  (frame_tick),
    .facing_left (facing_left),
`endif
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .draw_x      (DrawX),
    .draw_y      (DrawY),
    .in_box      (in_box),
    .address     (rom_address)
  );

  // A die on a tick cycle only enters PLAY; the tick is not counted.
  always_comb begin
    state_n = state;
    frame_n = frame_sel;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        if (die) begin
          state_n = PLAY;
          frame_n = '0;
          hold_n  = '0;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
            hold_n = '0;
            if (frame_sel == 2'(NUM_FRAMES - 1)) state_n = DONE;
            else                                  frame_n = frame_sel + 2'd1;
          end else begin
            hold_n = hold_cnt + HOLD_W'(1);
          end
        end
      end
      DONE:    ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state     <= IDLE;
      frame_sel <= '0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      frame_sel <= frame_n;
      hold_cnt  <= hold_n;
      busy      <= (state_n == PLAY);
      done      <= (state_n == DONE);
    end
  end

  // in_box rides alongside the address register and ROM read so that
  // valid_sr[ROM_LAT] lines up with rom_q.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      valid_sr  <= '0;
      sprite_on <= 1'b0;
      index_out <= '0;
    end else begin
      valid_sr[0] <= in_box;
      for (int unsigned i = 1; i <= ROM_LAT; i++) valid_sr[i] <= valid_sr[i-1];
      index_out <= rom_q;
      sprite_on <= valid_sr[ROM_LAT] && (rom_q != PAL_IDX_W'(TRANSP_IDX));
    end
  end

endmodule

// File: tb/tb_knight_death_anim_ctrl.sv
module tb_knight_death_anim_ctrl;

  logic        vga_clk;
  logic        Reset;
  logic        frame_tick;
  logic        die;
  logic        facing_left;
  logic [9:0]  pos_x, pos_y, DrawX, DrawY;
  logic [2:0]  rom_q;
  logic [11:0] rom_address;
  logic [1:0]  frame_sel;
  logic        sprite_on;
  logic [2:0]  index_out;
  logic        busy, done;

  int n_cmp = 0;
  int n_err = 0;

  knight_death_anim_ctrl dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .die         (die),
`ifdef KNIGHT_DEATH_MIRROR_EN
    .facing_left (facing_left),
`endif
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom_q       (rom_q),
    .rom_address (rom_address),
    .frame_sel   (frame_sel),
    .sprite_on   (sprite_on),
    .index_out   (index_out),
    .busy        (busy),
    .done        (done)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic [9:0]  px, py, dx, dy;
    logic [2:0]  q;
    logic [11:0] addr;
    logic        on;
    logic [2:0]  idx;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge vga_clk);
    Reset = 1'b0;
  endtask

  task automatic start_anim();
    die = 1'b1;
    @(negedge vga_clk);
    die = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; die = 1'b0; facing_left = 1'b0;
    pos_x = '0; pos_y = '0; DrawX = '0; DrawY = '0; rom_q = '0;

    //         px     py     dx     dy     q     addr      on    idx
    vecs[0] = '{10'd100, 10'd200, 10'd149, 10'd263, 3'd5, 12'd3199, 1'b1, 3'd5};
    vecs[1] = '{10'd100, 10'd200, 10'd150, 10'd263, 3'd5, 12'd0,    1'b0, 3'd5};
    vecs[2] = '{10'd100, 10'd200, 10'd100, 10'd200, 3'd0, 12'd0,    1'b0, 3'd0};
    vecs[3] = '{10'd100, 10'd200, 10'd100, 10'd200, 3'd3, 12'd0,    1'b1, 3'd3};
    vecs[4] = '{10'd100, 10'd200, 10'd99,  10'd200, 3'd3, 12'd0,    1'b0, 3'd3};
    vecs[5] = '{10'd100, 10'd200, 10'd120, 10'd210, 3'd7, 12'd520,  1'b1, 3'd7};
    vecs[6] = '{10'd100, 10'd200, 10'd120, 10'd264, 3'd7, 12'd0,    1'b0, 3'd7};
    vecs[7] = '{10'd600, 10'd0,   10'd639, 10'd5,   3'd2, 12'd289,  1'b1, 3'd2};
    vecs[8] = '{10'd1000,10'd0,   10'd639, 10'd5,   3'd2, 12'd0,    1'b0, 3'd2};
    vecs[9] = '{10'd1000,10'd0,   10'd5,   10'd5,   3'd2, 12'd0,    1'b0, 3'd2};

    repeat (2) @(negedge vga_clk);
    chk("rst_frame_sel", frame_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_address", rom_address, 0);
    chk("rst_sprite_on", sprite_on, 0);
    chk("rst_index_out", index_out, 0);
    Reset = 1'b0;

    // Steady-state address/visibility table
    for (int i = 0; i < 10; i++) begin
      pos_x = vecs[i].px; pos_y = vecs[i].py;
      DrawX = vecs[i].dx; DrawY = vecs[i].dy; rom_q = vecs[i].q;
      repeat (4) @(negedge vga_clk);
      chk($sformatf("vec%0d_addr", i), rom_address, vecs[i].addr);
      chk($sformatf("vec%0d_on", i), sprite_on, vecs[i].on);
      chk($sformatf("vec%0d_idx", i), index_out, vecs[i].idx);
    end

    // Single in-box pixel: address after 1 cycle, sprite_on exactly at 3
    pos_x = 10'd100; pos_y = 10'd200; DrawX = 10'd150; DrawY = 10'd263; rom_q = 3'd5;
    repeat (4) @(negedge vga_clk);
    DrawX = 10'd149;
    @(negedge vga_clk);
    chk("lat_addr_c1", rom_address, 3199);
    chk("lat_on_c1", sprite_on, 0);
    DrawX = 10'd150;
    @(negedge vga_clk);
    chk("lat_addr_c2", rom_address, 0);
    chk("lat_on_c2", sprite_on, 0);
    @(negedge vga_clk);
    chk("lat_on_c3", sprite_on, 1);
    chk("lat_idx_c3", index_out, 5);
    @(negedge vga_clk);
    chk("lat_on_c4", sprite_on, 0);

    // Full animation; die coincides with a tick that must not count
    do_reset();
    die = 1'b1; frame_tick = 1'b1;
    @(negedge vga_clk);
    die = 1'b0; frame_tick = 1'b0;
    chk("play_busy", busy, 1);
    chk("play_frame0", frame_sel, 0);
    for (int t = 1; t <= 32; t++) begin
      tick();
      if (t == 7)  chk("t7_frame", frame_sel, 0);
      if (t == 8)  begin chk("t8_frame", frame_sel, 1); chk("t8_busy", busy, 1); end
      if (t == 16) chk("t16_frame", frame_sel, 2);
      if (t == 23) chk("t23_frame", frame_sel, 2);
      if (t == 24) begin chk("t24_frame", frame_sel, 3); chk("t24_done", done, 0); end
      if (t == 31) begin chk("t31_done", done, 0); chk("t31_busy", busy, 1); end
      if (t == 32) begin
        chk("t32_done", done, 1);
        chk("t32_busy", busy, 0);
        chk("t32_frame", frame_sel, 3);
      end
    end
    start_anim();
    tick();
    chk("done_die_frame", frame_sel, 3);
    chk("done_die_done", done, 1);
    chk("done_die_busy", busy, 0);

    // Reset mid-animation at frame 2 with a visible pixel
    pos_x = 10'd100; pos_y = 10'd200; DrawX = 10'd110; DrawY = 10'd210; rom_q = 3'd5;
    do_reset();
    start_anim();
    repeat (16) tick();
    chk("mid_frame2", frame_sel, 2);
    chk("mid_busy", busy, 1);
    chk("mid_sprite_on", sprite_on, 1);
    Reset = 1'b1;
    @(negedge vga_clk);
    Reset = 1'b0;
    chk("mrst_frame", frame_sel, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_on_c1", sprite_on, 0);
    @(negedge vga_clk);
    chk("mrst_on_c2", sprite_on, 0);
    @(negedge vga_clk);
    chk("mrst_on_c3", sprite_on, 0);
    @(negedge vga_clk);
    chk("mrst_on_c4", sprite_on, 1);

`ifdef KNIGHT_DEATH_MIRROR_EN
    DrawX = 10'd100; DrawY = 10'd200;
    facing_left = 1'b1;
    repeat (2) @(negedge vga_clk);
    chk("mirror_unlatched", rom_address, 0);
    tick();
    chk("mirror_addr", rom_address, 49);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
